// File: rtl/alu_issue_stage_pkg.sv
// Shared definitions for the ALU issue stage: ALU op codes, RV32I opcodes,
// operand-select and control-state encodings.
package alu_issue_stage_pkg;

    localparam logic [5:0] ALU_OP_NONE            = 6'd0;
    localparam logic [5:0] ALU_OP_PLUS            = 6'd1;
    localparam logic [5:0] ALU_OP_SUB             = 6'd2;
    localparam logic [5:0] ALU_OP_SHIFT_LEFT      = 6'd3;
    localparam logic [5:0] ALU_OP_SET_LESS_THAN   = 6'd4;
    localparam logic [5:0] ALU_OP_SET_LESS_THAN_U = 6'd5;
    localparam logic [5:0] ALU_OP_XOR             = 6'd6;
    localparam logic [5:0] ALU_OP_SHIFT_RIGHT     = 6'd7;
    localparam logic [5:0] ALU_OP_SHIFT_RIGHT_A   = 6'd8;
    localparam logic [5:0] ALU_OP_OR              = 6'd9;
    localparam logic [5:0] ALU_OP_AND             = 6'd10;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        SEL_A_ZERO = 2'd0,
        SEL_A_RS1  = 2'd1,
        SEL_A_PC   = 2'd2
    } sel_a_t;

    typedef enum logic [1:0] {
        SEL_B_ZERO = 2'd0,
        SEL_B_RS2  = 2'd1,
        SEL_B_IMM  = 2'd2
    } sel_b_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

endpackage

// File: rtl/alu_issue_stage_decoder.sv
// Combinational RV32I decode into ALU op, enable, operand selects and shift masking.
module alu_issue_stage_decoder
    import alu_issue_stage_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    output logic       alu_e,
    output logic [5:0] alu_op,
    output sel_a_t     sel_a,
    output sel_b_t     sel_b,
    output logic       shamt_mask,
    output logic       illegal
);

    // Decode table; undecodable encodings force zero operands and a disabled ALU.
    always_comb begin
        alu_e      = 1'b1;
        alu_op     = ALU_OP_NONE;
        sel_a      = SEL_A_RS1;
        sel_b      = SEL_B_IMM;
        shamt_mask = 1'b0;
        illegal    = 1'b0;
        case (opcode)
            OPC_OP, OPC_OP_IMM: begin
                sel_b = (opcode == OPC_OP) ? SEL_B_RS2 : SEL_B_IMM;
                case (funct3)
                    3'b000: alu_op = ((opcode == OPC_OP) && funct7_5) ? ALU_OP_SUB : ALU_OP_PLUS;
                    3'b001: begin
                        alu_op     = ALU_OP_SHIFT_LEFT;
                        shamt_mask = 1'b1;
                    end
                    3'b010: alu_op = ALU_OP_SET_LESS_THAN;
                    3'b011: alu_op = ALU_OP_SET_LESS_THAN_U;
                    3'b100: alu_op = ALU_OP_XOR;
                    3'b101: begin
                        alu_op     = funct7_5 ? ALU_OP_SHIFT_RIGHT_A : ALU_OP_SHIFT_RIGHT;
                        shamt_mask = 1'b1;
                    end
                    3'b110: alu_op = ALU_OP_OR;
                    3'b111: alu_op = ALU_OP_AND;
                    default: alu_op = ALU_OP_NONE;
                endcase
            end
            OPC_LUI: begin
                alu_op = ALU_OP_PLUS;
                sel_a  = SEL_A_ZERO;
            end
            OPC_AUIPC: begin
                alu_op = ALU_OP_PLUS;
                sel_a  = SEL_A_PC;
            end
            OPC_LOAD, OPC_STORE, OPC_JALR: alu_op = ALU_OP_PLUS;
            OPC_BRANCH: begin
                sel_b = SEL_B_RS2;
                case (funct3[2:1])
                    2'b00: alu_op = ALU_OP_SUB;
                    2'b10: alu_op = ALU_OP_SET_LESS_THAN;
                    2'b11: alu_op = ALU_OP_SET_LESS_THAN_U;
                    default: begin
                        alu_e   = 1'b0;
                        sel_a   = SEL_A_ZERO;
                        sel_b   = SEL_B_ZERO;
                        illegal = 1'b1;
                    end
                endcase
            end
            default: begin
                alu_e   = 1'b0;
                sel_a   = SEL_A_ZERO;
                sel_b   = SEL_B_ZERO;
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/alu_issue_stage.sv
// Decode/issue stage feeding the integer ALU through a registered 2-entry skid buffer.
// Optional operand forwarding is enabled by defining ALU_ISSUE_FWD_EN.
module alu_issue_stage
    import alu_issue_stage_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  flush,
`ifdef ALU_ISSUE_FWD_EN
    input  logic [4:0]            rs1_addr,
    input  logic [4:0]            rs2_addr,
    input  logic                  fwd_valid,
    input  logic [4:0]            fwd_rd,
    input  logic [DATA_WIDTH-1:0] fwd_data,
`endif
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [6:0]            opcode,
    input  logic [2:0]            funct3,
    input  logic                  funct7_5,
    input  logic [DATA_WIDTH-1:0] pc,
    input  logic [DATA_WIDTH-1:0] rs1_data,
    input  logic [DATA_WIDTH-1:0] rs2_data,
    input  logic [DATA_WIDTH-1:0] imm,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  alu_e,
    output logic [5:0]            alu_op,
    output logic [DATA_WIDTH-1:0] alu_a,
    output logic [DATA_WIDTH-1:0] alu_b,
    output logic                  illegal
);

    localparam int SHW = $clog2(DATA_WIDTH);

    logic                  dec_e_s;
    logic [5:0]            dec_op_s;
    sel_a_t                sel_a_s;
    sel_b_t                sel_b_s;
    logic                  shamt_mask_s;
    logic                  dec_ill_s;
    logic [DATA_WIDTH-1:0] rs1_s;
    logic [DATA_WIDTH-1:0] rs2_s;
    logic [DATA_WIDTH-1:0] a_s;
    logic [DATA_WIDTH-1:0] b_raw_s;
    logic [DATA_WIDTH-1:0] b_s;
    logic                  in_fire_s;
    logic                  out_fire_s;

    state_t                state_r;
    logic                  skid_e_r;
    logic [5:0]            skid_op_r;
    logic [DATA_WIDTH-1:0] skid_a_r;
    logic [DATA_WIDTH-1:0] skid_b_r;
    logic                  skid_ill_r;

    alu_issue_stage_decoder u_decoder (
        .opcode     (opcode),
        .funct3     (funct3),
        .funct7_5   (funct7_5),
        .alu_e      (dec_e_s),
        .alu_op     (dec_op_s),
        .sel_a      (sel_a_s),
        .sel_b      (sel_b_s),
        .shamt_mask (shamt_mask_s),
        .illegal    (dec_ill_s)
    );

    assign in_fire_s  = in_valid & in_ready;
    assign out_fire_s = out_valid & out_ready;

    // Register-file values, optionally overridden by an in-flight writeback (x0 never forwards).
    always_comb begin
`ifdef ALU_ISSUE_FWD_EN
        rs1_s = (fwd_valid && (fwd_rd == rs1_addr) && (fwd_rd != 5'd0)) ? fwd_data : rs1_data;
        rs2_s = (fwd_valid && (fwd_rd == rs2_addr) && (fwd_rd != 5'd0)) ? fwd_data : rs2_data;
`else
        rs1_s = rs1_data;
        rs2_s = rs2_data;
`endif
    end

    // Operand selection; shift amounts keep only the low SHW bits of B.
    always_comb begin
        case (sel_a_s)
            SEL_A_RS1: a_s = rs1_s;
            SEL_A_PC:  a_s = pc;
            default:   a_s = '0;
        endcase
        case (sel_b_s)
            SEL_B_RS2: b_raw_s = rs2_s;
            SEL_B_IMM: b_raw_s = imm;
            default:   b_raw_s = '0;
        endcase
        if (shamt_mask_s) begin
            b_s = {{(DATA_WIDTH-SHW){1'b0}}, b_raw_s[SHW-1:0]};
        end else begin
            b_s = b_raw_s;
        end
    end

    // Skid-buffer control: main register drives the ALU, skid absorbs one beat of backpressure.
    always_ff @(posedge clk) begin
        if (!reset_n || flush) begin
            state_r    <= ST_EMPTY;
            out_valid  <= 1'b0;
            in_ready   <= 1'b1;
            alu_e      <= 1'b0;
            alu_op     <= ALU_OP_NONE;
            alu_a      <= '0;
            alu_b      <= '0;
            illegal    <= 1'b0;
            skid_e_r   <= 1'b0;
            skid_op_r  <= ALU_OP_NONE;
            skid_a_r   <= '0;
            skid_b_r   <= '0;
            skid_ill_r <= 1'b0;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (in_fire_s) begin
                        alu_e     <= dec_e_s;
                        alu_op    <= dec_op_s;
                        alu_a     <= a_s;
                        alu_b     <= b_s;
                        illegal   <= dec_ill_s;
                        out_valid <= 1'b1;
                        state_r   <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (in_fire_s && out_fire_s) begin
                        alu_e   <= dec_e_s;
                        alu_op  <= dec_op_s;
                        alu_a   <= a_s;
                        alu_b   <= b_s;
                        illegal <= dec_ill_s;
                    end else if (in_fire_s) begin
                        skid_e_r   <= dec_e_s;
                        skid_op_r  <= dec_op_s;
                        skid_a_r   <= a_s;
                        skid_b_r   <= b_s;
                        skid_ill_r <= dec_ill_s;
                        in_ready   <= 1'b0;
                        state_r    <= ST_TWO;
                    end else if (out_fire_s) begin
                        out_valid <= 1'b0;
                        state_r   <= ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (out_fire_s) begin
                        alu_e    <= skid_e_r;
                        alu_op   <= skid_op_r;
                        alu_a    <= skid_a_r;
                        alu_b    <= skid_b_r;
                        illegal  <= skid_ill_r;
                        in_ready <= 1'b1;
                        state_r  <= ST_ONE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state_r   <= ST_EMPTY;
                end
            endcase
        end
    end

endmodule
